bank_frame_reader: RTL and testbench

//  Read-side controller for a switch bank. It drains one stored frame at a time from the bank's

---
 rtl/bank_pkg.sv | 21 ++
 rtl/bank_skid2.sv | 70 +++++++
 rtl/bank_frame_reader.sv | 140 ++++++++++++++
 tb/tb_bank_frame_reader.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bank_pkg.sv
// Shared types and default constants for the bank read-side controller.
package bank_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DESC,
    LOAD,
    STREAM,
    GAP
  } rd_state_t;

  localparam int cBANK_BITS = 8;
  localparam int cLEN_W     = 11;
  localparam int cIFG       = 12;

  // Gap counter width; a zero gap still needs a 1-bit register to stay legal.
  function automatic int ifg_cnt_w(input int ifg);
    return (ifg > 0) ? $clog2(ifg + 1) : 1;
  endfunction

endpackage

// File: rtl/bank_skid2.sv
// Two-entry skid FIFO holding returned bank bytes with their sof/eof tags
// until the egress port accepts them.
module bank_skid2
  import bank_pkg::*;
#(
  parameter int pBITS = cBANK_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [pBITS-1:0] push_data_i,
  input  logic             push_sof_i,
  input  logic             push_eof_i,
  input  logic             pop_i,
  output logic [1:0]       occ_o,
  output logic [pBITS-1:0] head_data_o,
  output logic             head_sof_o,
  output logic             head_eof_o
);

  typedef struct packed {
    logic             sof;
    logic             eof;
    logic [pBITS-1:0] data;
  } entry_t;

  entry_t     mem_q [2];
  logic       rd_ptr_q;
  logic       wr_ptr_q;
  logic [1:0] occ_q;
  logic       pop_ok;
  logic       push_ok;

  assign pop_ok  = pop_i && (occ_q != 2'd0);
  assign push_ok = push_i && ((occ_q != 2'd2) || pop_ok);

  // NOTE: the two storage entries are reset along with the pointers so the
  // egress data bus reads zero out of reset rather than X; at two entries
  // this is cheap, unlike resetting a real RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      // NOTE: every register here uses <= so all of them see the pre-edge
      // values of each other; blocking = would make results order-dependent.
      if (push_ok) begin
        mem_q[wr_ptr_q] <= '{sof: push_sof_i, eof: push_eof_i, data: push_data_i};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_ok, pop_ok})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign occ_o       = occ_q;
  assign head_data_o = mem_q[rd_ptr_q].data;
  assign head_sof_o  = mem_q[rd_ptr_q].sof;
  assign head_eof_o  = mem_q[rd_ptr_q].eof;

endmodule

// File: rtl/bank_frame_reader.sv
// Drains one stored frame at a time from a bank byte FIFO onto an egress
// stream, covering the FIFO read latency, backpressure and inter-frame gap.
module bank_frame_reader
  import bank_pkg::*;
#(
  parameter int pBITS  = cBANK_BITS,
  parameter int pLEN_W = cLEN_W,
  parameter int pIFG   = cIFG
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              idesc_empty,
  input  logic [pLEN_W-1:0] idesc_len,
  output logic              odesc_rd,
  input  logic              ififo_empty,
  input  logic [pBITS-1:0]  ififo_data,
  output logic              ofifo_rd,
  output logic              otx_valid,
  output logic [pBITS-1:0]  otx_data,
  output logic              otx_sof,
  output logic              otx_eof,
  input  logic              itx_ready,
  output logic              oerr_len,
  output logic              obusy
);

  localparam int IFG_W = ifg_cnt_w(pIFG);

  rd_state_t         state_q;
  logic [pLEN_W-1:0] rem_q;
  logic [pLEN_W-1:0] txcnt_q;
  logic [IFG_W-1:0]  ifg_q;
  logic              inflight_q;
  logic              inflight_sof_q;
  logic              inflight_eof_q;
  logic              first_rd_q;

  logic [1:0]        occ;
  logic [pBITS-1:0]  head_data;
  logic              head_sof;
  logic              head_eof;
  logic              pop;
  logic              rd_en;
  logic [2:0]        fill;

  assign pop  = otx_valid && itx_ready;
  assign fill = {1'b0, occ} + {2'b00, inflight_q};

  // Reads start in LOAD so the first byte reaches the port four cycles after
  // the descriptor strobe; a same-cycle pop frees a slot for the next read.
  always_comb begin
    // NOTE: rd_en gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    rd_en = 1'b0;
    if ((state_q == LOAD || state_q == STREAM) && !ififo_empty && (rem_q != '0)) begin
      rd_en = (fill < (3'd2 + {2'b00, pop}));
    end
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_q        <= IDLE;
      rem_q          <= '0;
      txcnt_q        <= '0;
      ifg_q          <= '0;
      inflight_q     <= 1'b0;
      inflight_sof_q <= 1'b0;
      inflight_eof_q <= 1'b0;
      first_rd_q     <= 1'b0;
    end else begin
      inflight_q     <= rd_en;
      inflight_sof_q <= rd_en && first_rd_q;
      inflight_eof_q <= rd_en && (rem_q == pLEN_W'(1));
      if (rd_en) begin
        rem_q      <= rem_q - pLEN_W'(1);
        first_rd_q <= 1'b0;
      end
      if (pop) begin
        txcnt_q <= txcnt_q - pLEN_W'(1);
      end

      case (state_q)
        IDLE: begin
          if (!idesc_empty) state_q <= DESC;
        end
        DESC: begin
          rem_q      <= idesc_len;
          txcnt_q    <= idesc_len;
          first_rd_q <= 1'b1;
          state_q    <= LOAD;
        end
        LOAD: begin
          state_q <= (txcnt_q == '0) ? IDLE : STREAM;
        end
        STREAM: begin
          if (pop && head_eof) begin
            if (pIFG > 0) begin
              state_q <= GAP;
              ifg_q   <= IFG_W'(pIFG);
            end else begin
              state_q <= IDLE;
            end
          end
        end
        GAP: begin
          ifg_q <= ifg_q - IFG_W'(1);
          if (ifg_q <= IFG_W'(1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  bank_skid2 #(
    .pBITS(pBITS)
  ) u_skid (
    .clk        (iclk),
    .rst        (ireset),
    .push_i     (inflight_q),
    .push_data_i(ififo_data),
    .push_sof_i (inflight_sof_q),
    .push_eof_i (inflight_eof_q),
    .pop_i      (pop),
    .occ_o      (occ),
    .head_data_o(head_data),
    .head_sof_o (head_sof),
    .head_eof_o (head_eof)
  );

  // The strobe is masked by reset so every output is low while it is held.
  assign odesc_rd  = (state_q == IDLE) && !idesc_empty && !ireset;
  assign ofifo_rd  = rd_en;
  assign otx_valid = (occ != 2'd0);
  assign otx_data  = head_data;
  assign otx_sof   = otx_valid && head_sof;
  assign otx_eof   = otx_valid && head_eof;
  assign oerr_len  = (state_q == LOAD) && (txcnt_q == '0);
  assign obusy     = (state_q != IDLE);

endmodule

// File: tb/tb_bank_frame_reader.sv
// Randomised bench for bank_frame_reader: a frame-level scoreboard plus FIFO
// models, with directed frames that pin exact cycle timing.
module tb_bank_frame_reader;

  localparam int BITS  = 8;
  localparam int LEN_W = 11;
  localparam int IFG   = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main DUT (gap of 12)
  logic             desc_empty = 1'b1;
  logic [LEN_W-1:0] desc_len   = '0;
  logic             desc_rd;
  logic             fifo_empty = 1'b1;
  logic [BITS-1:0]  fifo_data  = '0;
  logic             fifo_rd;
  logic             tx_valid, tx_sof, tx_eof, err_len, busy;
  logic [BITS-1:0]  tx_data;
  logic             tx_ready = 1'b1;

  bank_frame_reader #(.pBITS(BITS), .pLEN_W(LEN_W), .pIFG(IFG)) u_dut (
    .iclk(clk), .ireset(rst),
    .idesc_empty(desc_empty), .idesc_len(desc_len), .odesc_rd(desc_rd),
    .ififo_empty(fifo_empty), .ififo_data(fifo_data), .ofifo_rd(fifo_rd),
    .otx_valid(tx_valid), .otx_data(tx_data), .otx_sof(tx_sof), .otx_eof(tx_eof),
    .itx_ready(tx_ready), .oerr_len(err_len), .obusy(busy)
  );

  // second DUT with no gap, back-to-back frames
  logic             b_desc_empty = 1'b1;
  logic [LEN_W-1:0] b_desc_len   = '0;
  logic             b_desc_rd;
  logic             b_fifo_empty = 1'b1;
  logic [BITS-1:0]  b_fifo_data  = '0;
  logic             b_fifo_rd;
  logic             b_tx_valid, b_tx_sof, b_tx_eof, b_err_len, b_busy;
  logic [BITS-1:0]  b_tx_data;
  logic             b_tx_ready = 1'b1;

  bank_frame_reader #(.pBITS(BITS), .pLEN_W(LEN_W), .pIFG(0)) u_dut_b0 (
    .iclk(clk), .ireset(rst),
    .idesc_empty(b_desc_empty), .idesc_len(b_desc_len), .odesc_rd(b_desc_rd),
    .ififo_empty(b_fifo_empty), .ififo_data(b_fifo_data), .ofifo_rd(b_fifo_rd),
    .otx_valid(b_tx_valid), .otx_data(b_tx_data), .otx_sof(b_tx_sof), .otx_eof(b_tx_eof),
    .itx_ready(b_tx_ready), .oerr_len(b_err_len), .obusy(b_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // FIFO models, reference queues and stimulus knobs
  logic [BITS-1:0] byte_q[$];
  int              desc_q[$];
  int              exp_len[$];
  logic [BITS-1:0] exp_byte[$];
  logic [9:0]      log_q[$];
  int              log_cyc[$];
  bit   rd_seen = 0, drd_seen = 0;
  bit   chk_en = 0;
  int   ready_mode = 0, ready_pct = 100, pat = 0;
  int   stall_after = -1, stall_cnt = 0, stall_pct = 0;
  int   rd_in_frame = 0, beat_idx = 0, gap_left = 0;
  bit   idle_due = 0;
  int   err_cnt = 0, stalls = 0;
  bit   prev_stall = 0;
  logic [BITS-1:0] prev_data;
  logic prev_sof, prev_eof;

  always @(negedge clk) begin
    rd_seen  = fifo_rd;
    drd_seen = desc_rd;
  end

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (drd_seen && desc_q.size() > 0) desc_len = LEN_W'(desc_q.pop_front());
      if (rd_seen && byte_q.size() > 0) fifo_data = byte_q.pop_front();
    end
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       begin tx_ready = (pat % 3 == 0); pat++; end
      default: tx_ready = ($urandom_range(0, 99) < ready_pct);
    endcase
    if (stall_after >= 0 && rd_in_frame == stall_after) begin
      stall_cnt   = 6;
      stall_after = -1;
    end else if (stall_pct > 0 && stall_cnt == 0 && $urandom_range(0, 99) < stall_pct) begin
      stall_cnt = $urandom_range(1, 4);
    end
    fifo_empty = (byte_q.size() == 0) || (stall_cnt > 0);
    if (stall_cnt > 0) stall_cnt--;
    desc_empty = (desc_q.size() == 0);
  end

  // Scoreboard: frames leave in order, bytes exactly as stored, sof on the
  // first, eof on the last, reads per frame equal to its length, then the gap.
  always @(negedge clk) begin
    if (!rst && chk_en) begin
      if (prev_stall) begin
        check("hold_valid", tx_valid, 1);
        check("hold_data", tx_data, prev_data);
        check("hold_sof", tx_sof, prev_sof);
        check("hold_eof", tx_eof, prev_eof);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_sof   = tx_sof;
      prev_eof   = tx_eof;
      if (prev_stall) stalls++;

      if (fifo_rd) begin
        check("rd_while_empty", fifo_empty, 0);
        rd_in_frame++;
      end

      if (gap_left > 0) begin
        check("gap_busy", busy, 1);
        check("gap_valid", tx_valid, 0);
        check("gap_desc_rd", desc_rd, 0);
        gap_left--;
        if (gap_left == 0) idle_due = 1;
      end else if (idle_due) begin
        check("gap_end_idle", busy, 0);
        idle_due = 0;
      end

      if (err_len) begin
        err_cnt++;
        if (exp_len.size() > 0) begin
          check("err_len_for_zero", exp_len[0], 0);
          void'(exp_len.pop_front());
        end else begin
          n_checks++; n_fail++;
          $display("FAIL err_len_spurious: pulse with no descriptor outstanding (cycle %0d)", cyc);
        end
        check("err_len_reads", rd_in_frame, 0);
        rd_in_frame = 0;
      end

      if (tx_valid && tx_ready) begin
        if (exp_len.size() == 0 || exp_byte.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL spurious_beat: got byte 0x%0h with no frame expected (cycle %0d)", tx_data, cyc);
        end else begin
          check("beat_data", tx_data, exp_byte.pop_front());
          check("beat_sof", tx_sof, beat_idx == 0);
          check("beat_eof", tx_eof, beat_idx == exp_len[0] - 1);
          log_q.push_back({tx_sof, tx_eof, tx_data});
          log_cyc.push_back(cyc);
          beat_idx++;
          if (beat_idx >= exp_len[0]) begin
            check("reads_per_frame", rd_in_frame, exp_len[0]);
            void'(exp_len.pop_front());
            beat_idx    = 0;
            rd_in_frame = 0;
            gap_left    = IFG;
          end
        end
      end
    end
  end

  // gap-free DUT models
  logic [BITS-1:0] b_byte_q[$];
  int              b_desc_q[$];
  logic [BITS-1:0] b_exp[$];
  int              b_drd_cyc[$];
  int              b_eof_cyc[$];
  bit b_rd_seen = 0, b_drd_seen = 0;

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (b_drd_seen && b_desc_q.size() > 0) b_desc_len = LEN_W'(b_desc_q.pop_front());
      if (b_rd_seen && b_byte_q.size() > 0) b_fifo_data = b_byte_q.pop_front();
    end
    b_fifo_empty = (b_byte_q.size() == 0);
    b_desc_empty = (b_desc_q.size() == 0);
  end

  always @(negedge clk) begin
    b_rd_seen  = b_fifo_rd;
    b_drd_seen = b_desc_rd;
    if (!rst) begin
      if (b_desc_rd) b_drd_cyc.push_back(cyc);
      if (b_tx_valid && b_tx_ready) begin
        if (b_exp.size() > 0) check("b_data", b_tx_data, b_exp.pop_front());
        if (b_tx_eof) b_eof_cyc.push_back(cyc);
      end
    end
  end

  task automatic push_frame(input int len, input int base);
    logic [BITS-1:0] b;
    desc_q.push_back(len);
    exp_len.push_back(len);
    for (int i = 0; i < len; i++) begin
      b = (base < 0) ? BITS'($urandom) : BITS'(base + i);
      byte_q.push_back(b);
      exp_byte.push_back(b);
    end
  endtask

  task automatic wait_desc(input string nm, input int max, output int at);
    bit seen = 0;
    at = -1;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk); #1;
      if (desc_rd) begin seen = 1; at = cyc; end
    end
    check({"timeout_", nm}, seen, 1);
  endtask

  task automatic wait_idle(input string nm, input int max, output int at);
    bit done = 0;
    at = -1;
    for (int i = 0; i < max && !done; i++) begin
      @(negedge clk); #1;
      if (exp_len.size() == 0 && desc_q.size() == 0 && !busy && gap_left == 0 && !idle_due) begin
        done = 1; at = cyc;
      end
    end
    check({"timeout_", nm}, done, 1);
  endtask

  initial begin
    int t0, at, n, len;
    bit hit;

    repeat (3) @(negedge clk);
    check("rst_valid", tx_valid, 0);
    check("rst_data", tx_data, 0);
    check("rst_sof_eof", {tx_sof, tx_eof}, 0);
    check("rst_strobes", {desc_rd, fifo_rd, err_len}, 0);
    check("rst_busy", busy, 0);
    rst    = 1'b0;
    chk_en = 1;

    // gap-free: next descriptor read on the cycle after eof is accepted
    b_desc_q.push_back(2);
    b_desc_q.push_back(2);
    for (int i = 0; i < 4; i++) begin
      b_byte_q.push_back(BITS'(8'h71 + i));
      b_exp.push_back(BITS'(8'h71 + i));
    end
    for (int i = 0; i < 100 && b_eof_cyc.size() < 2; i++) @(negedge clk);
    check("t6_eofs", b_eof_cyc.size(), 2);
    check("t6_desc_rds", b_drd_cyc.size(), 2);
    if (b_eof_cyc.size() >= 1 && b_drd_cyc.size() >= 2) begin
      check("t6_first_latency", b_eof_cyc[0] - b_drd_cyc[0], 5);
      check("t6_back_to_back", b_drd_cyc[1], b_eof_cyc[0] + 1);
    end

    // len=4, full rate: bytes on t0+4..t0+7, 12 gap cycles, idle at t0+20
    log_q.delete(); log_cyc.delete();
    push_frame(4, 'h11);
    wait_desc("t1_desc", 50, t0);
    wait_idle("t1", 200, at);
    check("t1_beats", log_q.size(), 4);
    if (log_q.size() == 4) begin
      check("t1_b0", log_q[0], {2'b10, 8'h11});
      check("t1_b1", log_q[1], {2'b00, 8'h12});
      check("t1_b2", log_q[2], {2'b00, 8'h13});
      check("t1_b3", log_q[3], {2'b01, 8'h14});
      check("t1_first_cyc", log_cyc[0], t0 + 4);
      check("t1_last_cyc", log_cyc[3], t0 + 7);
    end
    check("t1_busy_fall", at, t0 + 20);

    // len=3 with ready 1,0,0 repeating
    ready_mode = 1; pat = 0; stalls = 0;
    log_q.delete(); log_cyc.delete();
    push_frame(3, 'h21);
    wait_idle("t2", 200, at);
    ready_mode = 0;
    check("t2_beats", log_q.size(), 3);
    check("t2_stalled", stalls >= 2, 1);

    // len=5 with the byte FIFO empty for 6 cycles after 2 reads
    log_q.delete(); log_cyc.delete();
    stall_after = 2;
    push_frame(5, 'h31);
    wait_idle("t3", 200, at);
    check("t3_beats", log_q.size(), 5);
    if (log_q.size() == 5) begin
      check("t3_valid_gap", (log_cyc[4] - log_cyc[0]) > 4, 1);
      check("t3_last", log_q[4], {2'b01, 8'h35});
    end

    // len=0 then len=1
    log_q.delete(); log_cyc.delete();
    err_cnt = 0;
    push_frame(0, 0);
    push_frame(1, 'hAA);
    wait_idle("t4", 200, at);
    check("t4_err_pulses", err_cnt, 1);
    check("t4_beats", log_q.size(), 1);
    if (log_q.size() == 1) check("t4_single", log_q[0], {2'b11, 8'hAA});

    // reset while byte 3 of a 6-byte frame is pending
    log_q.delete(); log_cyc.delete();
    push_frame(6, 'h51);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk); #1;
      if (beat_idx == 2) hit = 1;
    end
    check("t5_reach_byte2", hit, 1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_valid", tx_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_strobes", {desc_rd, fifo_rd, err_len}, 0);
    chk_en = 0;
    repeat (2) @(posedge clk);
    byte_q.delete(); desc_q.delete(); exp_len.delete(); exp_byte.delete();
    beat_idx = 0; rd_in_frame = 0; gap_left = 0; idle_due = 0; prev_stall = 0;
    stall_cnt = 0; stall_after = -1;
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1;
    log_q.delete(); log_cyc.delete();
    push_frame(2, 'h61);
    wait_idle("t5", 200, at);
    check("t5_beats", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("t5_b0", log_q[0], {2'b10, 8'h61});
      check("t5_b1", log_q[1], {2'b01, 8'h62});
    end

    // random lengths, random backpressure and underflow
    ready_mode = 2; ready_pct = 70; stall_pct = 10;
    n = 0;
    for (int f = 0; f < 25; f++) begin
      len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 24));
      push_frame(len, -1);
      n += len;
    end
    log_q.delete(); log_cyc.delete();
    wait_idle("rand", 8000, at);
    check("rand_total_beats", log_q.size(), n);
    ready_mode = 0; stall_pct = 0;

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
